cheri_lsu_stkz_arb: RTL and testbench

Arbiter that shares the single LSU request/response port between the core load/store path and the stack-zeroization engine. It holds each granted request stable until the LSU accepts it. It tags every accepted transaction with its owner and routes in-order responses back to the correct requester. Core traffic has priority, and a bounded-wait counter guarantees that zeroization makes forward progress. It sits between the pipeline's LSU front end and the load/store unit, alongside the zeroization engine.

---
 rtl/cheri_lsu_stkz_arb.sv | 199 +++++++++++++++++++
 tb/tb_cheri_lsu_stkz_arb.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cheri_lsu_stkz_arb.sv
// Shares the single LSU request port between the core load/store path and the
// stack-zeroization engine, with owner tagging for in-order response routing.
module cheri_lsu_stkz_arb #(
   parameter int MAX_OUTST     = 2,
   parameter int STKZ_MAX_WAIT = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic        core_is_cap_i,
   input  logic [31:0] core_addr_i,
   input  logic [32:0] core_wdata_i,
   output logic        core_req_done_o,
   output logic        core_resp_valid_o,
   output logic        core_resp_err_o,
   output logic [32:0] core_rdata_o,
   input  logic        stkz_req_i,
   input  logic        stkz_we_i,
   input  logic        stkz_is_cap_i,
   input  logic [31:0] stkz_addr_i,
   input  logic [32:0] stkz_wdata_i,
   input  logic        stkz_abort_i,
   output logic        stkz_req_done_o,
   output logic        stkz_resp_valid_o,
   output logic        stkz_resp_err_o,
   output logic        lsu_req_o,
   output logic        lsu_we_o,
   output logic        lsu_is_cap_o,
   output logic [31:0] lsu_addr_o,
   output logic [32:0] lsu_wdata_o,
   input  logic        lsu_req_done_i,
   input  logic        lsu_resp_valid_i,
   input  logic        lsu_resp_err_i,
   input  logic [32:0] lsu_rdata_i,
   output logic        arb_busy_o,
   output logic        unexp_resp_o
);

   localparam int CW = $clog2(MAX_OUTST + 1);
   localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTST);
   localparam logic [3:0]    MAX_WAIT = 4'(STKZ_MAX_WAIT);
   localparam logic          OWN_CORE = 1'b0;
   localparam logic          OWN_STKZ = 1'b1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOCK_CORE = 2'd1,
      LOCK_STKZ = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [CW-1:0]       count_r;
   logic [PW-1:0]       rd_ptr_r;
   logic [PW-1:0]       wr_ptr_r;
   logic [(1<<PW)-1:0]  tag_r;
   logic [3:0]          wait_r;
   logic                unexp_r;

   logic room_s;
   logic core_elig_s;
   logic stkz_elig_s;
   logic grant_s;
   logic owner_s;
   logic push_s;
   logic pop_s;
   logic head_s;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(MAX_OUTST - 1)) begin
         return {PW{1'b0}};
      end else begin
         return p + PW'(1);
      end
   endfunction

   assign room_s      = (count_r < MAX_CNT);
   assign core_elig_s = room_s & core_req_i;
   assign stkz_elig_s = room_s & stkz_req_i & ~stkz_abort_i;

   // Arbitration, lock hold and next-state selection.
   always_comb begin
      state_nxt_s = state_r;
      grant_s     = 1'b0;
      owner_s     = OWN_CORE;
      case (state_r)
         IDLE: begin
            if (core_elig_s | stkz_elig_s) begin
               grant_s = 1'b1;
               owner_s = stkz_elig_s & ((wait_r == MAX_WAIT) | ~core_elig_s);
               if (lsu_req_done_i) begin
                  state_nxt_s = IDLE;
               end else begin
                  state_nxt_s = owner_s ? LOCK_STKZ : LOCK_CORE;
               end
            end else begin
               grant_s = 1'b0;
            end
         end
         LOCK_CORE: begin
            grant_s     = 1'b1;
            owner_s     = OWN_CORE;
            state_nxt_s = lsu_req_done_i ? IDLE : LOCK_CORE;
         end
         LOCK_STKZ: begin
            grant_s     = 1'b1;
            owner_s     = OWN_STKZ;
            state_nxt_s = lsu_req_done_i ? IDLE : LOCK_STKZ;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
      // Nothing is offered to the LSU while reset is held.
      grant_s = grant_s & ~rst_i;
   end

   assign push_s = grant_s & lsu_req_done_i;
   assign pop_s  = lsu_resp_valid_i & (count_r != {CW{1'b0}}) & ~rst_i;
   assign head_s = tag_r[rd_ptr_r];

   assign lsu_req_o    = grant_s;
   assign lsu_we_o     = grant_s & (owner_s ? stkz_we_i : core_we_i);
   assign lsu_is_cap_o = grant_s & (owner_s ? stkz_is_cap_i : core_is_cap_i);
   assign lsu_addr_o   = grant_s ? (owner_s ? stkz_addr_i : core_addr_i) : 32'h0;
   assign lsu_wdata_o  = grant_s ? (owner_s ? stkz_wdata_i : core_wdata_i) : 33'h0;

   assign core_req_done_o   = push_s & (owner_s == OWN_CORE);
   assign stkz_req_done_o   = push_s & (owner_s == OWN_STKZ);
   assign core_resp_valid_o = pop_s & (head_s == OWN_CORE);
   assign core_resp_err_o   = core_resp_valid_o & lsu_resp_err_i;
   assign core_rdata_o      = core_resp_valid_o ? lsu_rdata_i : 33'h0;
   assign stkz_resp_valid_o = pop_s & (head_s == OWN_STKZ);
   assign stkz_resp_err_o   = stkz_resp_valid_o & lsu_resp_err_i;

   assign arb_busy_o   = (count_r != {CW{1'b0}}) | (state_r != IDLE);
   assign unexp_resp_o = unexp_r;

   // FSM state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Owner-tag FIFO and outstanding counter.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_r  <= {CW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         tag_r    <= '0;
      end else begin
         if (push_s) begin
            tag_r[wr_ptr_r] <= owner_s;
            wr_ptr_r        <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Bounded-wait counter for zeroization forward progress.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wait_r <= 4'd0;
      end else if (!stkz_req_i) begin
         wait_r <= 4'd0;
      end else if ((state_r == IDLE) && grant_s && (owner_s == OWN_STKZ)) begin
         wait_r <= 4'd0;
      end else if ((state_r == IDLE) && grant_s && stkz_elig_s && (wait_r != MAX_WAIT)) begin
         wait_r <= wait_r + 4'd1;
      end else begin
         wait_r <= wait_r;
      end
   end

   // Sticky flag for responses with nothing outstanding.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         unexp_r <= 1'b0;
      end else if (lsu_resp_valid_i && (count_r == {CW{1'b0}})) begin
         unexp_r <= 1'b1;
      end else begin
         unexp_r <= unexp_r;
      end
   end

endmodule

// File: tb/tb_cheri_lsu_stkz_arb.sv
// Bench for cheri_lsu_stkz_arb: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model.
module tb_cheri_lsu_stkz_arb;

   localparam int MAXO = 2;
   localparam int MAXW = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_req, core_we, core_cap;
   logic [31:0] core_addr;
   logic [32:0] core_wdata;
   logic        stkz_req, stkz_we, stkz_cap, stkz_abort;
   logic [31:0] stkz_addr;
   logic [32:0] stkz_wdata;
   logic        lsu_done, lsu_rv, lsu_rerr;
   logic [32:0] lsu_rdata;

   logic        core_req_done, core_resp_valid, core_resp_err;
   logic [32:0] core_rdata;
   logic        stkz_req_done, stkz_resp_valid, stkz_resp_err;
   logic        lsu_req, lsu_we, lsu_cap;
   logic [31:0] lsu_addr;
   logic [32:0] lsu_wdata;
   logic        arb_busy, unexp_resp;

   int checks = 0;
   int failures = 0;

   // reference model state
   int q[$];
   int locked = -1;
   int wait_m = 0;
   bit unexp_m = 1'b0;

   bit e_gnt, e_idle_gnt, e_se, e_push, e_pop;
   int e_owner, e_head;

   always #5 clk = ~clk;

   cheri_lsu_stkz_arb #(.MAX_OUTST(MAXO), .STKZ_MAX_WAIT(MAXW)) dut (
      .clk_i(clk), .rst_i(rst),
      .core_req_i(core_req), .core_we_i(core_we), .core_is_cap_i(core_cap),
      .core_addr_i(core_addr), .core_wdata_i(core_wdata),
      .core_req_done_o(core_req_done), .core_resp_valid_o(core_resp_valid),
      .core_resp_err_o(core_resp_err), .core_rdata_o(core_rdata),
      .stkz_req_i(stkz_req), .stkz_we_i(stkz_we), .stkz_is_cap_i(stkz_cap),
      .stkz_addr_i(stkz_addr), .stkz_wdata_i(stkz_wdata), .stkz_abort_i(stkz_abort),
      .stkz_req_done_o(stkz_req_done), .stkz_resp_valid_o(stkz_resp_valid),
      .stkz_resp_err_o(stkz_resp_err),
      .lsu_req_o(lsu_req), .lsu_we_o(lsu_we), .lsu_is_cap_o(lsu_cap),
      .lsu_addr_o(lsu_addr), .lsu_wdata_o(lsu_wdata),
      .lsu_req_done_i(lsu_done), .lsu_resp_valid_i(lsu_rv),
      .lsu_resp_err_i(lsu_rerr), .lsu_rdata_i(lsu_rdata),
      .arb_busy_o(arb_busy), .unexp_resp_o(unexp_resp)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Who gets the port this cycle, from the arbitration rules.
   task automatic model_eval();
      bit room, ce;
      e_gnt = 1'b0; e_idle_gnt = 1'b0; e_se = 1'b0; e_owner = 0;
      if (!rst) begin
         if (locked >= 0) begin
            e_gnt = 1'b1;
            e_owner = locked;
         end else begin
            room = (q.size() < MAXO);
            ce = room && core_req;
            e_se = room && stkz_req && !stkz_abort;
            e_gnt = ce || e_se;
            e_owner = (e_se && (wait_m == MAXW || !ce)) ? 1 : 0;
            e_idle_gnt = e_gnt;
         end
      end
      e_push = e_gnt && lsu_done;
      e_pop = !rst && lsu_rv && (q.size() > 0);
      e_head = e_pop ? q[0] : 0;
   endtask

   task automatic check_outputs();
      bit cv, sv;
      #1;
      model_eval();
      cv = e_pop && e_head == 0;
      sv = e_pop && e_head == 1;
      check_val("lsu_req", 64'(lsu_req), 64'(e_gnt));
      check_val("lsu_we", 64'(lsu_we), 64'(e_gnt && (e_owner == 1 ? stkz_we : core_we)));
      check_val("lsu_cap", 64'(lsu_cap), 64'(e_gnt && (e_owner == 1 ? stkz_cap : core_cap)));
      check_val("lsu_addr", 64'(lsu_addr), e_gnt ? 64'(e_owner == 1 ? stkz_addr : core_addr) : 64'd0);
      check_val("lsu_wdata", 64'(lsu_wdata), e_gnt ? 64'(e_owner == 1 ? stkz_wdata : core_wdata) : 64'd0);
      check_val("core_done", 64'(core_req_done), 64'(e_push && e_owner == 0));
      check_val("stkz_done", 64'(stkz_req_done), 64'(e_push && e_owner == 1));
      check_val("core_rv", 64'(core_resp_valid), 64'(cv));
      check_val("core_err", 64'(core_resp_err), 64'(cv && lsu_rerr));
      check_val("core_rdata", 64'(core_rdata), cv ? 64'(lsu_rdata) : 64'd0);
      check_val("stkz_rv", 64'(stkz_resp_valid), 64'(sv));
      check_val("stkz_err", 64'(stkz_resp_err), 64'(sv && lsu_rerr));
      check_val("busy", 64'(arb_busy), 64'(!rst && (q.size() > 0 || locked >= 0)));
      check_val("unexp", 64'(unexp_resp), 64'(!rst && unexp_m));
   endtask

   task automatic advance();
      @(posedge clk);
      if (rst) begin
         q.delete();
         locked = -1;
         wait_m = 0;
         unexp_m = 1'b0;
      end else begin
         if (lsu_rv && q.size() == 0) unexp_m = 1'b1;
         if (e_pop) void'(q.pop_front());
         if (e_push) begin
            q.push_back(e_owner);
            locked = -1;
         end else if (e_gnt) begin
            locked = e_owner;
         end
         if (!stkz_req) wait_m = 0;
         else if (e_idle_gnt && e_owner == 1) wait_m = 0;
         else if (e_idle_gnt && e_se && wait_m < MAXW) wait_m++;
      end
      @(negedge clk);
   endtask

   task automatic step();
      check_outputs();
      advance();
   endtask

   task automatic idle_inputs();
      core_req = 0; core_we = 0; core_cap = 0; core_addr = 0; core_wdata = 0;
      stkz_req = 0; stkz_we = 0; stkz_cap = 0; stkz_addr = 0; stkz_wdata = 0;
      stkz_abort = 0; lsu_done = 0; lsu_rv = 0; lsu_rerr = 0; lsu_rdata = 0;
   endtask

   initial begin
      bit seq[6];
      bit cdone, sdone;
      seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      core_req = 1'b1; core_addr = 32'h1234;
      step();                                      // outputs held at zero in reset
      core_req = 1'b0; core_addr = 32'h0;
      rst = 1'b0;
      step();

      // core-only: same-cycle done, response two cycles later
      core_req = 1; core_addr = 32'h0000_1000; core_wdata = 33'h1_DEAD_BEEF; core_we = 1; lsu_done = 1;
      check_outputs();
      check_val("t1_done", 64'(core_req_done), 64'd1);
      check_val("t1_addr", 64'(lsu_addr), 64'h1000);
      advance();
      idle_inputs();
      step();
      lsu_rv = 1; lsu_rdata = 33'h1_0000_00AB;
      check_outputs();
      check_val("t1_rv", 64'(core_resp_valid), 64'd1);
      check_val("t1_rdata", 64'(core_rdata), 64'h1_0000_00AB);
      check_val("t1_srv", 64'(stkz_resp_valid), 64'd0);
      advance();
      idle_inputs();

      // priority + lock hold, then full FIFO blocks a third grant
      core_req = 1; core_addr = 32'hA000_0010; stkz_req = 1; stkz_addr = 32'h5000_0020;
      for (int i = 0; i < 3; i++) begin
         check_outputs();
         check_val("t2_lock_addr", 64'(lsu_addr), 64'hA000_0010);
         advance();
      end
      lsu_done = 1;
      check_outputs();
      check_val("t2_cdone", 64'(core_req_done), 64'd1);
      check_val("t2_sdone0", 64'(stkz_req_done), 64'd0);
      advance();
      core_req = 0;
      check_outputs();
      check_val("t2_sdone", 64'(stkz_req_done), 64'd1);
      check_val("t2_saddr", 64'(lsu_addr), 64'h5000_0020);
      advance();
      stkz_req = 0; lsu_done = 0; core_req = 1; core_addr = 32'hA000_0030;
      check_outputs();
      check_val("t4_full_block", 64'(lsu_req), 64'd0);
      check_val("t2_sdone_once", 64'(stkz_req_done), 64'd0);
      advance();
      lsu_rv = 1; lsu_rdata = 33'h0_0000_0055;
      check_outputs();
      check_val("t4_first_resp_core", 64'(core_resp_valid), 64'd1);
      check_val("t4_still_full", 64'(lsu_req), 64'd0);
      advance();
      lsu_rv = 0; lsu_done = 1;
      check_outputs();
      check_val("t4_regrant", 64'(core_req_done), 64'd1);
      advance();
      core_req = 0; lsu_done = 0; lsu_rv = 1;
      check_outputs();
      check_val("t4_second_resp_stkz", 64'(stkz_resp_valid), 64'd1);
      advance();
      step();
      idle_inputs();

      // starvation bound: core, core, stkz, core, core, stkz
      for (int i = 0; i < 6; i++) begin
         core_req = 1; stkz_req = 1; lsu_done = 1;
         core_addr = 32'(i); stkz_addr = 32'h5000_0000 + 32'(i);
         lsu_rv = (q.size() > 0);
         check_outputs();
         check_val("t3_owner", 64'(stkz_req_done), 64'(seq[i]));
         advance();
      end
      idle_inputs();
      for (int i = 0; i < MAXO && q.size() > 0; i++) begin
         lsu_rv = 1;
         step();
      end
      idle_inputs();

      // abort during LOCK_STKZ
      stkz_req = 1; stkz_addr = 32'h5000_0100;
      step();
      stkz_abort = 1; core_req = 1; core_addr = 32'hC000_0000;
      check_outputs();
      check_val("t5_lock_addr", 64'(lsu_addr), 64'h5000_0100);
      advance();
      lsu_done = 1;
      check_outputs();
      check_val("t5_sdone", 64'(stkz_req_done), 64'd1);
      advance();
      core_req = 0; lsu_done = 0;
      check_outputs();
      check_val("t5_no_grant", 64'(lsu_req), 64'd0);
      advance();
      lsu_rv = 1; lsu_rerr = 1;
      check_outputs();
      check_val("t5_srv", 64'(stkz_resp_valid), 64'd1);
      check_val("t5_serr", 64'(stkz_resp_err), 64'd1);
      advance();
      idle_inputs();

      // unexpected responses, before and after a mid-lock reset
      lsu_rv = 1;
      check_outputs();
      check_val("t6_no_valid", 64'(core_resp_valid | stkz_resp_valid), 64'd0);
      advance();
      lsu_rv = 0;
      check_outputs();
      check_val("t6_unexp", 64'(unexp_resp), 64'd1);
      advance();
      core_req = 1;
      step();
      rst = 1;
      step();
      rst = 0; core_req = 0; lsu_rv = 1;
      check_outputs();
      check_val("t6_post_rst_valid", 64'(core_resp_valid | stkz_resp_valid), 64'd0);
      advance();
      lsu_rv = 0;
      check_outputs();
      check_val("t6_post_rst_unexp", 64'(unexp_resp), 64'd1);
      advance();
      rst = 1;
      step();
      rst = 0;
      idle_inputs();

      // randomized traffic with protocol-abiding requesters
      for (int n = 0; n < 2000; n++) begin
         if (!core_req) begin
            core_addr = $urandom;
            core_wdata = {1'($urandom_range(0, 1)), 32'($urandom)};
            core_we = 1'($urandom_range(0, 1));
            core_cap = 1'($urandom_range(0, 1));
            core_req = ($urandom_range(0, 2) == 0);
         end
         if (!stkz_req) begin
            stkz_addr = $urandom;
            stkz_wdata = {1'($urandom_range(0, 1)), 32'($urandom)};
            stkz_we = 1'($urandom_range(0, 1));
            stkz_cap = 1'($urandom_range(0, 1));
            stkz_req = ($urandom_range(0, 2) == 0);
         end
         stkz_abort = ($urandom_range(0, 7) == 0);
         lsu_done = 1'($urandom_range(0, 1));
         lsu_rv = (q.size() > 0) && ($urandom_range(0, 1) == 1);
         lsu_rerr = 1'($urandom_range(0, 1));
         lsu_rdata = {1'($urandom_range(0, 1)), 32'($urandom)};
         check_outputs();
         cdone = e_push && e_owner == 0;
         sdone = e_push && e_owner == 1;
         advance();
         if (cdone) core_req = 0;
         if (sdone) stkz_req = 0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
